// File: rtl/cdb_arbiter_if.sv
// Handshake and broadcast bundle between the two CDB producers (EX, SLB),
// the arbiter, and the reorder-buffer completion port.
interface cdb_arbiter_if #(
  parameter int NICK_W = 5,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              ex_valid;
  logic              ex_ready;
  logic [NICK_W-1:0] ex_nick;
  logic [DATA_W-1:0] ex_dt;
  logic              ex_ac;
  logic [ADDR_W-1:0] ex_j_pc;

  logic              slb_valid;
  logic              slb_ready;
  logic [NICK_W-1:0] slb_nick;
  logic [DATA_W-1:0] slb_dt;

  logic              cdb_valid;
  logic              cdb_src;
  logic [NICK_W-1:0] cdb_nick;
  logic [DATA_W-1:0] cdb_dt;
  logic              cdb_ac;
  logic [ADDR_W-1:0] cdb_j_pc;

  // Producer/consumer side: offers results and observes the broadcast.
  modport master (
    output ex_valid, ex_nick, ex_dt, ex_ac, ex_j_pc,
    output slb_valid, slb_nick, slb_dt,
    input  ex_ready, slb_ready,
    input  cdb_valid, cdb_src, cdb_nick, cdb_dt, cdb_ac, cdb_j_pc
  );

  // Arbiter side.
  modport slave (
    input  ex_valid, ex_nick, ex_dt, ex_ac, ex_j_pc,
    input  slb_valid, slb_nick, slb_dt,
    output ex_ready, slb_ready,
    output cdb_valid, cdb_src, cdb_nick, cdb_dt, cdb_ac, cdb_j_pc
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: buffers EX and SLB results in small FIFOs and
// broadcasts one per cycle to the ROB with round-robin fairness.
module cdb_arbiter #(
  parameter int NICK_W = 5,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         clr,
  cdb_arbiter_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [NICK_W-1:0] nick;
    logic [DATA_W-1:0] dt;
    logic              ac;
    logic [ADDR_W-1:0] j_pc;
  } ex_ent_t;

  typedef struct packed {
    logic [NICK_W-1:0] nick;
    logic [DATA_W-1:0] dt;
  } slb_ent_t;

  // FIFO storage (data only, never reset)
  ex_ent_t  ex_mem_q  [DEPTH];
  ex_ent_t  ex_mem_d  [DEPTH];
  slb_ent_t slb_mem_q [DEPTH];
  slb_ent_t slb_mem_d [DEPTH];

  logic [PTR_W-1:0] ex_wptr_q, ex_wptr_d, ex_rptr_q, ex_rptr_d;
  logic [PTR_W-1:0] slb_wptr_q, slb_wptr_d, slb_rptr_q, slb_rptr_d;
  logic [CNT_W-1:0] ex_cnt_q, ex_cnt_d, slb_cnt_q, slb_cnt_d;
  logic             rr_q, rr_d;

  logic              cdb_valid_q, cdb_valid_d;
  logic              cdb_src_q, cdb_src_d;
  logic [NICK_W-1:0] cdb_nick_q, cdb_nick_d;
  logic [DATA_W-1:0] cdb_dt_q, cdb_dt_d;
  logic              cdb_ac_q, cdb_ac_d;
  logic [ADDR_W-1:0] cdb_j_pc_q, cdb_j_pc_d;

  logic    ex_ready, slb_ready;
  logic    ex_push, slb_push;
  logic    ex_has, slb_has;
  logic    run;
  logic    grant_ex, grant_slb;
  ex_ent_t  ex_in, ex_head;
  slb_ent_t slb_in, slb_head;

  // Readiness looks only at the registered count: a full FIFO refuses even
  // in a cycle where it is about to pop.
  always_comb begin
    ex_ready  = rdy & ~rst & (ex_cnt_q  < CNT_W'(DEPTH));
    slb_ready = rdy & ~rst & (slb_cnt_q < CNT_W'(DEPTH));
  end

  assign bus.ex_ready  = ex_ready;
  assign bus.slb_ready = slb_ready;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_src   = cdb_src_q;
  assign bus.cdb_nick  = cdb_nick_q;
  assign bus.cdb_dt    = cdb_dt_q;
  assign bus.cdb_ac    = cdb_ac_q;
  assign bus.cdb_j_pc  = cdb_j_pc_q;

  always_comb begin
    ex_in.nick  = bus.ex_nick;
    ex_in.dt    = bus.ex_dt;
    ex_in.ac    = bus.ex_ac;
    ex_in.j_pc  = bus.ex_j_pc;
    slb_in.nick = bus.slb_nick;
    slb_in.dt   = bus.slb_dt;
    ex_head     = ex_mem_q[ex_rptr_q];
    slb_head    = slb_mem_q[slb_rptr_q];
  end

  // Tag 0 means "no tag": such an offer completes the handshake but is not stored.
  always_comb begin
    ex_push   = bus.ex_valid  & ex_ready  & ~clr & (bus.ex_nick  != '0);
    slb_push  = bus.slb_valid & slb_ready & ~clr & (bus.slb_nick != '0);
    ex_has    = (ex_cnt_q  != '0);
    slb_has   = (slb_cnt_q != '0);
    run       = rdy & ~clr;
    grant_ex  = run & ex_has  & (~slb_has | ~rr_q);
    grant_slb = run & slb_has & (~ex_has  |  rr_q);
  end

  // ---- FIFO pointer / count update ----
  always_comb begin
    ex_mem_d   = ex_mem_q;
    slb_mem_d  = slb_mem_q;
    ex_wptr_d  = ex_wptr_q;
    ex_rptr_d  = ex_rptr_q;
    slb_wptr_d = slb_wptr_q;
    slb_rptr_d = slb_rptr_q;

    if (ex_push) begin
      ex_mem_d[ex_wptr_q] = ex_in;
      ex_wptr_d           = ex_wptr_q + PTR_W'(1);
    end
    if (grant_ex) begin
      ex_rptr_d = ex_rptr_q + PTR_W'(1);
    end
    if (slb_push) begin
      slb_mem_d[slb_wptr_q] = slb_in;
      slb_wptr_d            = slb_wptr_q + PTR_W'(1);
    end
    if (grant_slb) begin
      slb_rptr_d = slb_rptr_q + PTR_W'(1);
    end

    ex_cnt_d  = ex_cnt_q  + CNT_W'(ex_push)  - CNT_W'(grant_ex);
    slb_cnt_d = slb_cnt_q + CNT_W'(slb_push) - CNT_W'(grant_slb);

    if (clr) begin
      ex_wptr_d  = '0;
      ex_rptr_d  = '0;
      slb_wptr_d = '0;
      slb_rptr_d = '0;
      ex_cnt_d   = '0;
      slb_cnt_d  = '0;
    end
  end

  // ---- Arbitration / broadcast register ----
  always_comb begin
    rr_d        = rr_q;
    cdb_valid_d = 1'b0;
    cdb_src_d   = cdb_src_q;
    cdb_nick_d  = cdb_nick_q;
    cdb_dt_d    = cdb_dt_q;
    cdb_ac_d    = cdb_ac_q;
    cdb_j_pc_d  = cdb_j_pc_q;

    if (grant_ex) begin
      rr_d        = 1'b1;
      cdb_valid_d = 1'b1;
      cdb_src_d   = 1'b0;
      cdb_nick_d  = ex_head.nick;
      cdb_dt_d    = ex_head.dt;
      cdb_ac_d    = ex_head.ac;
      cdb_j_pc_d  = ex_head.j_pc;
    end else if (grant_slb) begin
      rr_d        = 1'b0;
      cdb_valid_d = 1'b1;
      cdb_src_d   = 1'b1;
      cdb_nick_d  = slb_head.nick;
      cdb_dt_d    = slb_head.dt;
      cdb_ac_d    = 1'b0;
      cdb_j_pc_d  = '0;
    end

    // A flush looks exactly like reset to the ROB side.
    if (clr) begin
      rr_d        = 1'b0;
      cdb_valid_d = 1'b0;
      cdb_src_d   = 1'b0;
      cdb_nick_d  = '0;
      cdb_dt_d    = '0;
      cdb_ac_d    = 1'b0;
      cdb_j_pc_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_wptr_q   <= '0;
      ex_rptr_q   <= '0;
      slb_wptr_q  <= '0;
      slb_rptr_q  <= '0;
      ex_cnt_q    <= '0;
      slb_cnt_q   <= '0;
      rr_q        <= 1'b0;
      cdb_valid_q <= 1'b0;
      cdb_src_q   <= 1'b0;
      cdb_nick_q  <= '0;
      cdb_dt_q    <= '0;
      cdb_ac_q    <= 1'b0;
      cdb_j_pc_q  <= '0;
    end else begin
      ex_wptr_q   <= ex_wptr_d;
      ex_rptr_q   <= ex_rptr_d;
      slb_wptr_q  <= slb_wptr_d;
      slb_rptr_q  <= slb_rptr_d;
      ex_cnt_q    <= ex_cnt_d;
      slb_cnt_q   <= slb_cnt_d;
      rr_q        <= rr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_src_q   <= cdb_src_d;
      cdb_nick_q  <= cdb_nick_d;
      cdb_dt_q    <= cdb_dt_d;
      cdb_ac_q    <= cdb_ac_d;
      cdb_j_pc_q  <= cdb_j_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    ex_mem_q  <= ex_mem_d;
    slb_mem_q <= slb_mem_d;
  end

endmodule
